dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the load/store stage's data-memory request interface.
- Samples level-held read, write and fence requests (`re`/`we`, `data_addr`, `wmask`, `data`, type selects, `fence`).
- Converts each one into a single valid/ready transaction on the backing data bus.
- Returns the aligned 64-bit read doubleword plus a one-cycle `mem_finish` pulse that releases the pipeline stall.

Parameters:
- ADDR_W, 64, request and bus address width.
- DATA_W, 64, data width; fixed at 64 (8 byte lanes).
- TIMEOUT_CYCLES, 255, cycles waited for bus handshake/response before an error completion; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- data_addr_i  in  ADDR_W  byte address of the request
- wmask_i  in  8  byte-lane write mask
- wdata_i  in  64  lane-aligned store data
- we_i  in  1  write request (level, held until finish)
- we_type_sel_i  in  3  000 B, 001 H, 010 W, 100 D, 111 none
- re_i  in  1  read request (level, held until finish)
- re_type_sel_i  in  3  same encoding as we_type_sel_i
- fence_i  in  1  fence request (level)
- rdata_o  out  64  aligned doubleword read data
- mem_finish_o  out  1  one-cycle completion pulse
- bus_err_o  out  1  pulses with mem_finish_o on bus error, timeout or illegal size
- misalign_o  out  1  pulses with mem_finish_o on misaligned access (optional feature)
- bus_req_valid_o  out  1  bus request valid
- bus_req_ready_i  in  1  bus request accepted
- bus_req_write_o  out  1  1 = write
- bus_req_addr_o  out  ADDR_W  {data_addr_i[ADDR_W-1:3],3'b000}
- bus_req_wdata_o  out  64  registered wdata_i
- bus_req_wstrb_o  out  8  registered wmask_i; 0 for reads
- bus_req_size_o  out  2  0 B, 1 H, 2 W, 3 D
- bus_resp_valid_i  in  1  response valid, single cycle
- bus_resp_rdata_i  in  64  response data
- bus_resp_err_i  in  1  response error

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE; counter cleared.
  - All outputs are 0, including rdata_o. bus_req_valid_o drops immediately, even mid-handshake.
- States and transitions:
  - IDLE -> REQ when we_i or re_i is 1.
    - Addr, wdata, wmask, write flag and size are latched on this edge.
    - we_i wins if both are set.
  - IDLE -> FENCE when fence_i=1 and neither we_i nor re_i is set.
  - REQ: bus_req_valid_o=1 with latched fields, held stable until bus_req_ready_i.
    - On ready -> WAIT.
    - A response in the same cycle as ready is not permitted by the bus.
  - WAIT: on bus_resp_valid_i -> DONE.
    - Read: rdata_o <= bus_resp_rdata_i.
    - Write: rdata_o unchanged.
    - bus_err flag <= bus_resp_err_i. On a read error rdata_o <= 0.
  - DONE: mem_finish_o=1 for exactly this cycle, with bus_err_o and misalign_o as flagged; then -> IDLE.
  - FENCE: one cycle, then -> DONE. Nothing is ever outstanding in IDLE, so a fence costs 2 cycles.
- Timeout:
  - A counter runs in REQ and WAIT and resets on each state entry.
  - When it reaches TIMEOUT_CYCLES: -> DONE with bus_err_o=1; in REQ bus_req_valid_o drops.
  - A late response arriving afterwards in IDLE is ignored.
- Illegal size: type select not in {000,001,010,100} with re/we set -> DONE directly, bus_err_o=1, no bus transaction.
- Latency (request-hold to finish): best case 3 cycles (IDLE->REQ, ready, resp, DONE).
- rdata_o holds its value until the next read completion. Lane extraction and sign extension are done by the requester.
- The requester advances on finish. A request still asserted in IDLE after DONE is treated as new and re-issued; this is idempotent for memory.

Optional Feature:
- Macro: DMEM_RESP_ALIGN_CHECK_EN.
- Defined: in IDLE, a misaligned access goes directly to DONE, with misalign_o=1, bus_err_o=0, no bus transaction, rdata_o unchanged. Misaligned means:
  - H with addr[0]!=0;
  - W with addr[1:0]!=0;
  - D with addr[2:0]!=0.
- Undefined: misalign_o tied 0; misaligned requests go to the bus unchanged.

Test Plan:
- Read: re_i=1, re_type_sel_i=100, addr 0x8000_0010, ready after 2 cycles, resp 0x1122334455667788 -> bus_req_addr_o=0x80000010, size 3, wstrb 0; single finish pulse; rdata_o=0x1122334455667788.
- Store byte: we_i=1, addr 0x8000_0005, wmask 0x20, wdata 0xAB<<40 -> bus_req_write_o=1, wstrb 0x20, addr 0x80000000, size 0; finish; rdata_o unchanged.
- Error and timeout:
  - Bus error: resp with err=1 on a read -> finish with bus_err_o=1, rdata_o=0.
  - Timeout: TIMEOUT_CYCLES=4, ready never asserted -> valid drops and finish+bus_err_o occur 4 cycles after REQ entry.
- Fence: fence_i=1 in IDLE -> finish 2 cycles later; no bus_req_valid_o.
- Reset mid-WAIT: assert rst -> all outputs 0 immediately. After release, a response arriving in IDLE produces no finish.
- Align check (DMEM_RESP_ALIGN_CHECK_EN): LW at 0x8000_0002 -> finish with misalign_o=1, no bus_req_valid_o. Without the macro: bus transaction with size 2.

Source files
------------

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_responder                                               |
// | Description : Memory-side responder that turns level-held load/store/fence |
// |               requests into one valid/ready bus transaction each and       |
// |               returns a single-cycle mem_finish_o pulse.                   |
// |               Optional alignment check: DMEM_RESP_ALIGN_CHECK_EN.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dmem_responder #(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [7:0]        wmask_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              we_i,
    input  logic [2:0]        we_type_sel_i,
    input  logic              re_i,
    input  logic [2:0]        re_type_sel_i,
    input  logic              fence_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_finish_o,
    output logic              bus_err_o,
    output logic              misalign_o,
    output logic              bus_req_valid_o,
    input  logic              bus_req_ready_i,
    output logic              bus_req_write_o,
    output logic [ADDR_W-1:0] bus_req_addr_o,
    output logic [DATA_W-1:0] bus_req_wdata_o,
    output logic [7:0]        bus_req_wstrb_o,
    output logic [1:0]        bus_req_size_o,
    input  logic              bus_resp_valid_i,
    input  logic [DATA_W-1:0] bus_resp_rdata_i,
    input  logic              bus_resp_err_i
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_REQ   = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_DONE  = 3'd3;
    localparam logic [2:0] c_ST_FENCE = 3'd4;

    // Counter only has to reach TIMEOUT_CYCLES-1 before the exit edge.
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST =
        c_CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [7:0]         r_wstrb;
    logic               r_write;
    logic [1:0]         r_size;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_err;
    logic [2:0]         w_sel;
    logic [1:0]         w_size;
    logic               w_size_ok;
    logic               w_misalign;
    logic               w_req;
    logic               w_tmo;

    assign w_req = we_i | re_i;
    assign w_sel = we_i ? we_type_sel_i : re_type_sel_i;
    assign w_tmo = (TIMEOUT_CYCLES != 0) && (r_cnt == c_CNT_LAST);

    always_comb begin
        w_size    = 2'd0;
        w_size_ok = 1'b1;
        case (w_sel)
            3'b000:  w_size = 2'd0;
            3'b001:  w_size = 2'd1;
            3'b010:  w_size = 2'd2;
            3'b100:  w_size = 2'd3;
            default: w_size_ok = 1'b0;
        endcase
    end

`ifdef DMEM_RESP_ALIGN_CHECK_EN
    logic r_misalign;

    always_comb begin
        w_misalign = 1'b0;
        case (w_size)
            2'd1:    w_misalign = data_addr_i[0];
            2'd2:    w_misalign = |data_addr_i[1:0];
            2'd3:    w_misalign = |data_addr_i[2:0];
            default: w_misalign = 1'b0;
        endcase
    end

    assign misalign_o = (r_state == c_ST_DONE) && r_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (r_state == c_ST_IDLE && (w_req || fence_i)) begin
            r_misalign <= w_req && w_size_ok && w_misalign;
        end
    end
`else
    logic w_unused_addr_lo;

    assign w_unused_addr_lo = ^data_addr_i[2:0];
    assign w_misalign       = 1'b0;
    assign misalign_o       = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_req) begin
                    w_state_nxt = (!w_size_ok || w_misalign) ? c_ST_DONE : c_ST_REQ;
                end else if (fence_i) begin
                    w_state_nxt = c_ST_FENCE;
                end
            end
            c_ST_REQ: begin
                if (bus_req_ready_i) begin
                    w_state_nxt = c_ST_WAIT;
                end else if (w_tmo) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_WAIT: begin
                if (bus_resp_valid_i || w_tmo) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            c_ST_FENCE: w_state_nxt = c_ST_DONE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= 8'h00;
            r_write <= 1'b0;
            r_size  <= 2'd0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state != w_state_nxt) begin
                r_cnt <= '0;
            end else if (r_state == c_ST_REQ || r_state == c_ST_WAIT) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_req) begin
                        r_err <= !w_size_ok;
                        if (w_size_ok && !w_misalign) begin
                            r_addr  <= {data_addr_i[ADDR_W-1:3], 3'b000};
                            r_wdata <= wdata_i;
                            r_wstrb <= we_i ? wmask_i : 8'h00;
                            r_write <= we_i;
                            r_size  <= w_size;
                        end
                    end else if (fence_i) begin
                        r_err <= 1'b0;
                    end
                end
                c_ST_REQ: begin
                    if (!bus_req_ready_i && w_tmo) begin
                        r_err <= 1'b1;
                    end
                end
                c_ST_WAIT: begin
                    if (bus_resp_valid_i) begin
                        r_err <= bus_resp_err_i;
                        // A failed read returns zero rather than stale bus data.
                        if (!r_write) begin
                            r_rdata <= bus_resp_err_i ? '0 : bus_resp_rdata_i;
                        end
                    end else if (w_tmo) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rdata_o         = r_rdata;
    assign mem_finish_o    = (r_state == c_ST_DONE);
    assign bus_err_o       = (r_state == c_ST_DONE) && r_err;
    assign bus_req_valid_o = (r_state == c_ST_REQ);
    assign bus_req_write_o = r_write;
    assign bus_req_addr_o  = r_addr;
    assign bus_req_wdata_o = r_wdata;
    assign bus_req_wstrb_o = r_wstrb;
    assign bus_req_size_o  = r_size;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dmem_responder                                            |
// | Description : Table-driven bench for dmem_responder plus reset-in-WAIT.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dmem_responder;

    localparam int c_TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] data_addr_i;
    logic [7:0]  wmask_i;
    logic [63:0] wdata_i;
    logic        we_i;
    logic [2:0]  we_type_sel_i;
    logic        re_i;
    logic [2:0]  re_type_sel_i;
    logic        fence_i;
    logic [63:0] rdata_o;
    logic        mem_finish_o;
    logic        bus_err_o;
    logic        misalign_o;
    logic        bus_req_valid_o;
    logic        bus_req_ready_i;
    logic        bus_req_write_o;
    logic [63:0] bus_req_addr_o;
    logic [63:0] bus_req_wdata_o;
    logic [7:0]  bus_req_wstrb_o;
    logic [1:0]  bus_req_size_o;
    logic        bus_resp_valid_i;
    logic [63:0] bus_resp_rdata_i;
    logic        bus_resp_err_i;

    int checks   = 0;
    int failures = 0;

    dmem_responder #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(c_TMO)) dut (
        .clk(clk), .rst(rst),
        .data_addr_i(data_addr_i), .wmask_i(wmask_i), .wdata_i(wdata_i),
        .we_i(we_i), .we_type_sel_i(we_type_sel_i),
        .re_i(re_i), .re_type_sel_i(re_type_sel_i), .fence_i(fence_i),
        .rdata_o(rdata_o), .mem_finish_o(mem_finish_o),
        .bus_err_o(bus_err_o), .misalign_o(misalign_o),
        .bus_req_valid_o(bus_req_valid_o), .bus_req_ready_i(bus_req_ready_i),
        .bus_req_write_o(bus_req_write_o), .bus_req_addr_o(bus_req_addr_o),
        .bus_req_wdata_o(bus_req_wdata_o), .bus_req_wstrb_o(bus_req_wstrb_o),
        .bus_req_size_o(bus_req_size_o),
        .bus_resp_valid_i(bus_resp_valid_i), .bus_resp_rdata_i(bus_resp_rdata_i),
        .bus_resp_err_i(bus_resp_err_i)
    );

    always #5 clk = ~clk;

    // Field order matters: vectors are written as positional patterns.
    typedef struct {
        logic        wr, rd, fn;
        logic [63:0] addr;
        logic [2:0]  wsel, rsel;
        logic [7:0]  wmask;
        logic [63:0] wdata;
        int          rdy_dly, rsp_dly;
        logic [63:0] rsp_data;
        logic        rsp_err;
        logic        exp_bus;
        logic [63:0] exp_addr;
        logic [1:0]  exp_size;
        logic [7:0]  exp_wstrb;
        logic        exp_write;
        int          exp_lat;
        logic        exp_err, exp_mis, chk_rd;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int idx);
        int  vcnt, wcnt, fin_cnt, fin_it, exp_vcnt;
        bit  hs;
        vcnt = 0; wcnt = 0; fin_cnt = 0; fin_it = -1; hs = 0;
        @(negedge clk);
        we_i = v.wr; re_i = v.rd; fence_i = v.fn;
        data_addr_i = v.addr; we_type_sel_i = v.wsel; re_type_sel_i = v.rsel;
        wmask_i = v.wmask; wdata_i = v.wdata;
        for (int it = 1; it <= 20; it++) begin
            @(negedge clk);
            bus_req_ready_i  = 1'b0;
            bus_resp_valid_i = 1'b0;
            bus_resp_err_i   = 1'b0;
            if (bus_req_valid_o) begin
                if (vcnt == 0) begin
                    chk($sformatf("v%0d_addr", idx), bus_req_addr_o, v.exp_addr);
                    chk($sformatf("v%0d_size", idx), 64'(bus_req_size_o), 64'(v.exp_size));
                    chk($sformatf("v%0d_wstrb", idx), 64'(bus_req_wstrb_o), 64'(v.exp_wstrb));
                    chk($sformatf("v%0d_write", idx), 64'(bus_req_write_o), 64'(v.exp_write));
                    if (v.exp_write)
                        chk($sformatf("v%0d_wdata", idx), bus_req_wdata_o, v.wdata);
                end
                if (vcnt == v.rdy_dly) begin
                    bus_req_ready_i = 1'b1;
                    hs = 1;
                end
                vcnt++;
            end else if (hs) begin
                if (wcnt == v.rsp_dly) begin
                    bus_resp_valid_i = 1'b1;
                    bus_resp_rdata_i = v.rsp_data;
                    bus_resp_err_i   = v.rsp_err;
                end
                wcnt++;
            end
            if (mem_finish_o) begin
                fin_cnt++;
                if (fin_cnt == 1) begin
                    fin_it = it;
                    chk($sformatf("v%0d_err", idx), 64'(bus_err_o), 64'(v.exp_err));
                    chk($sformatf("v%0d_mis", idx), 64'(misalign_o), 64'(v.exp_mis));
                    if (v.chk_rd)
                        chk($sformatf("v%0d_rdata", idx), rdata_o, v.exp_rdata);
                end
                we_i = 1'b0; re_i = 1'b0; fence_i = 1'b0;
            end
        end
        exp_vcnt = !v.exp_bus ? 0 : (v.rdy_dly >= 99 ? c_TMO : v.rdy_dly + 1);
        chk($sformatf("v%0d_valid_cycles", idx), 64'(vcnt), 64'(exp_vcnt));
        chk($sformatf("v%0d_finish_count", idx), 64'(fin_cnt), 64'd1);
        chk($sformatf("v%0d_latency", idx), 64'(fin_it), 64'(v.exp_lat));
        we_i = 1'b0; re_i = 1'b0; fence_i = 1'b0;
    endtask

    initial begin
        int fin_cnt;
        //           wr rd fn addr             wsel    rsel    wmask  wdata
        //           rdy rsp rsp_data               err  bus exp_addr      size wstrb  wr  lat err mis chk rdata
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 64'h8000_0010, 3'b111, 3'b100, 8'h00, 64'h0,
                     2, 0, 64'h1122_3344_5566_7788, 1'b0,
                     1'b1, 64'h8000_0010, 2'd3, 8'h00, 1'b0, 5, 1'b0, 1'b0, 1'b1, 64'h1122_3344_5566_7788};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 64'h8000_0005, 3'b000, 3'b111, 8'h20, 64'h0000_AB00_0000_0000,
                     0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                     1'b1, 64'h8000_0000, 2'd0, 8'h20, 1'b1, 4, 1'b0, 1'b0, 1'b1, 64'h1122_3344_5566_7788};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 64'h8000_0008, 3'b111, 3'b010, 8'h00, 64'h0,
                     1, 2, 64'hDEAD_BEEF_CAFE_F00D, 1'b0,
                     1'b1, 64'h8000_0008, 2'd2, 8'h00, 1'b0, 6, 1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 64'h8000_0004, 3'b111, 3'b001, 8'h00, 64'h0,
                     0, 0, 64'h0102_0304_0506_0708, 1'b0,
                     1'b1, 64'h8000_0000, 2'd1, 8'h00, 1'b0, 3, 1'b0, 1'b0, 1'b1, 64'h0102_0304_0506_0708};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 64'h8000_0018, 3'b111, 3'b100, 8'h00, 64'h0,
                     0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                     1'b1, 64'h8000_0018, 2'd3, 8'h00, 1'b0, 3, 1'b1, 1'b0, 1'b1, 64'h0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 64'h8000_0020, 3'b010, 3'b111, 8'h0F, 64'h0000_0000_1234_5678,
                     0, 0, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1,
                     1'b1, 64'h8000_0020, 2'd2, 8'h0F, 1'b1, 3, 1'b1, 1'b0, 1'b1, 64'h0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 64'h0, 3'b111, 3'b111, 8'h00, 64'h0,
                     0, 0, 64'h0, 1'b0,
                     1'b0, 64'h0, 2'd0, 8'h00, 1'b0, 2, 1'b0, 1'b0, 1'b1, 64'h0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 64'h8000_0000, 3'b000, 3'b011, 8'h00, 64'h0,
                     0, 0, 64'h0, 1'b0,
                     1'b0, 64'h0, 2'd0, 8'h00, 1'b0, 1, 1'b1, 1'b0, 1'b1, 64'h0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 64'h8000_0000, 3'b111, 3'b100, 8'hFF, 64'h0,
                     0, 0, 64'h0, 1'b0,
                     1'b0, 64'h0, 2'd0, 8'h00, 1'b0, 1, 1'b1, 1'b0, 1'b1, 64'h0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 64'h8000_0042, 3'b001, 3'b100, 8'h0C, 64'h0000_0000_BEEF_0000,
                     0, 0, 64'h7777_7777_7777_7777, 1'b0,
                     1'b1, 64'h8000_0040, 2'd1, 8'h0C, 1'b1, 3, 1'b0, 1'b0, 1'b1, 64'h0};
`ifdef DMEM_RESP_ALIGN_CHECK_EN
        vecs[10] = '{1'b0, 1'b1, 1'b0, 64'h8000_0002, 3'b111, 3'b010, 8'h00, 64'h0,
                     0, 0, 64'h5555_AAAA_5555_AAAA, 1'b0,
                     1'b0, 64'h0, 2'd0, 8'h00, 1'b0, 1, 1'b0, 1'b1, 1'b1, 64'h0};
`else
        vecs[10] = '{1'b0, 1'b1, 1'b0, 64'h8000_0002, 3'b111, 3'b010, 8'h00, 64'h0,
                     0, 0, 64'h5555_AAAA_5555_AAAA, 1'b0,
                     1'b1, 64'h8000_0000, 2'd2, 8'h00, 1'b0, 3, 1'b0, 1'b0, 1'b1, 64'h5555_AAAA_5555_AAAA};
`endif
        vecs[11] = '{1'b0, 1'b1, 1'b0, 64'h8000_0060, 3'b111, 3'b100, 8'h00, 64'h0,
                     99, 0, 64'h0, 1'b0,
                     1'b1, 64'h8000_0060, 2'd3, 8'h00, 1'b0, 5, 1'b1, 1'b0, 1'b0, 64'h0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 64'h8000_0068, 3'b111, 3'b100, 8'h00, 64'h0,
                     0, 99, 64'h0, 1'b0,
                     1'b1, 64'h8000_0068, 2'd3, 8'h00, 1'b0, 6, 1'b1, 1'b0, 1'b0, 64'h0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 64'h8000_0070, 3'b111, 3'b100, 8'h00, 64'h0,
                     0, 0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0,
                     1'b1, 64'h8000_0070, 2'd3, 8'h00, 1'b0, 3, 1'b0, 1'b0, 1'b1, 64'h0F0F_0F0F_0F0F_0F0F};

        rst = 1'b1;
        data_addr_i = '0; wmask_i = '0; wdata_i = '0;
        we_i = 1'b0; we_type_sel_i = 3'b111; re_i = 1'b0; re_type_sel_i = 3'b111; fence_i = 1'b0;
        bus_req_ready_i = 1'b0; bus_resp_valid_i = 1'b0; bus_resp_rdata_i = '0; bus_resp_err_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_finish", 64'(mem_finish_o), 64'd0);
        chk("reset_valid", 64'(bus_req_valid_o), 64'd0);
        chk("reset_rdata", rdata_o, 64'd0);
        chk("reset_err", 64'(bus_err_o), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) run(vecs[i], i);

        // Reset while a read is outstanding, then a stray response in IDLE.
        @(negedge clk);
        re_i = 1'b1; re_type_sel_i = 3'b100; data_addr_i = 64'h8000_0080;
        @(negedge clk);
        chk("rstw_valid_req", 64'(bus_req_valid_o), 64'd1);
        bus_req_ready_i = 1'b1;
        @(negedge clk);
        bus_req_ready_i = 1'b0;
        chk("rstw_in_wait", 64'(bus_req_valid_o), 64'd0);
        chk("rstw_rdata_before", rdata_o, 64'h0F0F_0F0F_0F0F_0F0F);
        rst = 1'b1; re_i = 1'b0;
        #1;
        chk("rstw_rdata", rdata_o, 64'd0);
        chk("rstw_valid", 64'(bus_req_valid_o), 64'd0);
        chk("rstw_finish", 64'(mem_finish_o), 64'd0);
        chk("rstw_addr", bus_req_addr_o, 64'd0);
        chk("rstw_write", 64'(bus_req_write_o), 64'd0);
        chk("rstw_size", 64'(bus_req_size_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_resp_valid_i = 1'b1; bus_resp_rdata_i = 64'h9999_9999_9999_9999;
        fin_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus_resp_valid_i = 1'b0;
            if (mem_finish_o || bus_req_valid_o) fin_cnt++;
        end
        chk("late_resp_ignored", 64'(fin_cnt), 64'd0);
        chk("late_resp_rdata", rdata_o, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
